// File: rtl/alu_core.sv
// Registered single-cycle ALU: eight operations selected by Alu_CTRL.
// Result and C/Z/N flags update on every rising clk edge.
module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Alu_CTRL,
  output logic [WIDTH-1:0] out,
  output logic             C,
  output logic             Z,
  output logic             N
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  alu_op_e            op;
  logic [4:0]         shamt;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   nxt_out;
  logic               nxt_c;

  assign op    = alu_op_e'(Alu_CTRL);
  assign shamt = B[4:0];

  // Shifts run one bit wider so the last bit shifted out lands in the
  // extra position; a zero shift leaves a zero there, giving C=0.
  always_comb begin
    add_ext = {1'b0, A} + {1'b0, B};
    sub_ext = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    prod    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    shl_ext = {1'b0, A} << shamt;
    shr_ext = {A, 1'b0} >> shamt;
  end

  always_comb begin
    nxt_out = '0;
    nxt_c   = 1'b0;
    case (op)
      OP_ADD: begin
        nxt_out = add_ext[WIDTH-1:0];
        nxt_c   = add_ext[WIDTH];
      end
      OP_SUB: begin
        nxt_out = sub_ext[WIDTH-1:0];
        nxt_c   = sub_ext[WIDTH];
      end
      OP_MUL: begin
        nxt_out = prod[WIDTH-1:0];
        nxt_c   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND: nxt_out = A & B;
      OP_OR:  nxt_out = A | B;
      OP_XOR: nxt_out = A ^ B;
      OP_SHL: begin
        nxt_out = shl_ext[WIDTH-1:0];
        nxt_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        nxt_out = shr_ext[WIDTH:1];
        nxt_c   = shr_ext[0];
      end
      default: begin
        nxt_out = '0;
        nxt_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      C   <= 1'b0;
      Z   <= 1'b1;
      N   <= 1'b0;
    end else begin
      out <= nxt_out;
      C   <= nxt_c;
      Z   <= ~|nxt_out;
      N   <= nxt_out[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Alu_CTRL;
  logic [31:0] out;
  logic        C;
  logic        Z;
  logic        N;

  int unsigned passed = 0;
  int unsigned total  = 0;

  alu_core #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Alu_CTRL (Alu_CTRL),
    .out      (out),
    .C        (C),
    .Z        (Z),
    .N        (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk_flags(input string tag, input logic ec, input logic ez, input logic en);
    chk({tag, ".C"}, {31'b0, C}, {31'b0, ec});
    chk({tag, ".Z"}, {31'b0, Z}, {31'b0, ez});
    chk({tag, ".N"}, {31'b0, N}, {31'b0, en});
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    A = a; B = b; Alu_CTRL = op;
    @(negedge clk);
  endtask

  logic [31:0] exp_out [8];
  logic        exp_c   [8];
  logic        exp_z   [8];
  logic        exp_n   [8];
  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [2:0]  vo [8];
  logic [31:0] vr [8];

  initial begin
    rst = 1'b0; A = '0; B = '0; Alu_CTRL = '0;

    // Reset with arbitrary inputs, before any clock edge
    #1;
    A = 32'hDEADBEEF; B = 32'h12345678; Alu_CTRL = 3'b010;
    rst = 1'b1;
    #1;
    chk("rst_out", out, 32'h0);
    chk_flags("rst", 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // A=3, B=10 across all opcodes
    exp_out = '{32'd13, 32'hFFFFFFF9, 32'd30, 32'd2, 32'd11, 32'd9, 32'd3072, 32'd0};
    exp_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_z   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_n   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(32'd3, 32'd10, 3'(i));
      chk($sformatf("op%0d_out", i), out, exp_out[i]);
      chk_flags($sformatf("op%0d", i), exp_c[i], exp_z[i], exp_n[i]);
    end

    // Carry/borrow edge cases
    run_op(32'hFFFFFFFF, 32'd1, 3'b000);
    chk("add_wrap_out", out, 32'h0);
    chk_flags("add_wrap", 1'b1, 1'b1, 1'b0);
    run_op(32'd5, 32'd5, 3'b001);
    chk("sub_eq_out", out, 32'h0);
    chk_flags("sub_eq", 1'b1, 1'b1, 1'b0);

    // Shift carry-out and multiply high-half
    run_op(32'h80000001, 32'd1, 3'b110);
    chk("shl_out", out, 32'h2);
    chk("shl_c", {31'b0, C}, 32'd1);
    run_op(32'h80000001, 32'd1, 3'b111);
    chk("shr_out", out, 32'h40000000);
    chk("shr_c", {31'b0, C}, 32'd1);
    chk("shr_n", {31'b0, N}, 32'd0);
    run_op(32'h00010000, 32'h00010000, 3'b010);
    chk("mul_ovf_out", out, 32'h0);
    chk_flags("mul_ovf", 1'b1, 1'b1, 1'b0);

    // Upper B bits ignored for shift amount; zero shift gives C=0
    run_op(32'h80000001, 32'h00000021, 3'b110);
    chk("shl_bhi_out", out, 32'h2);
    chk("shl_bhi_c", {31'b0, C}, 32'd1);
    run_op(32'h80000001, 32'hFFFFFFE0, 3'b111);
    chk("shr_zero_out", out, 32'h80000001);
    chk_flags("shr_zero", 1'b0, 1'b0, 1'b1);

    // Back-to-back pipeline: result i appears exactly one cycle after issue
    va = '{32'd1, 32'd100, 32'd7, 32'hF0, 32'hF0, 32'hFF, 32'd1, 32'h100};
    vb = '{32'd2, 32'd1,   32'd6, 32'h3C, 32'h0F, 32'h0F, 32'd4, 32'd4};
    vo = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    vr = '{32'd3, 32'd99, 32'd42, 32'h30, 32'hFF, 32'hF0, 32'd16, 32'h10};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      A = va[i]; B = vb[i]; Alu_CTRL = vo[i];
      #1;
      if (i > 0) chk($sformatf("b2b%0d_hold", i), out, vr[i-1]);
      @(negedge clk);
      chk($sformatf("b2b%0d_out", i), out, vr[i]);
    end

    // Mid-stream reset: issue an op, let it load, then reset asynchronously
    A = 32'd40; B = 32'd2; Alu_CTRL = 3'b000;
    @(posedge clk);
    #2;
    chk("pre_rst_out", out, 32'd42);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", out, 32'h0);
    chk_flags("mid_rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_hold_out", out, 32'h0);

    // First edge after release loads the op present there
    A = 32'h7FFFFFFF; B = 32'd1; Alu_CTRL = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out", out, 32'h80000000);
    chk_flags("post_rst", 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width in bits; all values below assume 32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port A, input, WIDTH bits: operand A, unsigned two's-complement bit vector.
REQ-005 The block SHALL have port B, input, WIDTH bits: operand B; B[4:0] is also the shift amount.
REQ-006 The block SHALL have port Alu_CTRL, input, 3 bits: operation select.
REQ-007 The block SHALL have port out, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port C, output, 1 bit: registered carry/borrow/overflow flag.
REQ-009 The block SHALL have port Z, output, 1 bit: registered zero flag.
REQ-010 The block SHALL have port N, output, 1 bit: registered negative flag.

Function
REQ-011 The block SHALL sample A, B and Alu_CTRL on every rising clk edge and present out/C/Z/N for that operation after the edge: latency 1 cycle, no enable, no handshake, new operation accepted every cycle.
REQ-012 Opcode 000 SHALL be ADD: out = (A+B) mod 2^WIDTH; C = carry out of the MSB.
REQ-013 Opcode 001 SHALL be SUB: out = (A-B) mod 2^WIDTH, computed as A + ~B + 1; C = carry out of that sum (C=1 no borrow, C=0 borrow; A=B gives C=1).
REQ-014 Opcode 010 SHALL be MUL: out = low WIDTH bits of unsigned A*B; C = 1 iff upper WIDTH bits of the full product are non-zero.
REQ-015 Opcodes 011, 100 and 101 SHALL be bitwise AND, OR and XOR respectively, each with C=0.
REQ-016 Opcode 110 SHALL be SHL: out = A << B[4:0], zero fill; C = last bit shifted out (A[WIDTH-B[4:0]]); C=0 when B[4:0]=0.
REQ-017 Opcode 111 SHALL be SHR logical: out = A >> B[4:0], zero fill; C = last bit shifted out (A[B[4:0]-1]); C=0 when B[4:0]=0.
REQ-018 B[WIDTH-1:5] SHALL be ignored for shifts.
REQ-019 Z SHALL be 1 iff the registered out is all zeros, for every opcode.
REQ-020 N SHALL equal the registered out[WIDTH-1], for every opcode.
REQ-021 Overflow in ADD/SUB/MUL SHALL wrap silently; no signed-overflow flag exists.
REQ-022 Outputs SHALL depend only on registered state, with no combinational path from inputs to outputs.

Reset
REQ-023 While rst=1, irrespective of clk, out SHALL be 0, C SHALL be 0, N SHALL be 0 and Z SHALL be 1.
REQ-024 Asserting rst mid-stream SHALL discard any in-flight result immediately.
REQ-025 After rst deasserts, the first rising clk edge SHALL load the operation present at that edge.

Verification
REQ-026 The bench SHALL apply rst=1 with arbitrary inputs and check out=0, C=0, N=0, Z=1 without a clock edge.
REQ-027 The bench SHALL apply A=3, B=10 with opcodes 000, 001, 010, 011, 100, 101, 110, 111 and, one cycle later, check out=13, 0xFFFFFFF9, 30, 2, 11, 9, 3072, 0 respectively.
REQ-028 The bench SHALL check the flags for REQ-027: opcode 001 gives C=0, N=1, Z=0; opcode 111 gives Z=1, C=0; all other opcodes give C=0, N=0, Z=0.
REQ-029 The bench SHALL apply A=0xFFFFFFFF, B=1 with opcode 000 and check out=0, C=1, Z=1, N=0; then A=5, B=5 with opcode 001 and check out=0, C=1, Z=1.
REQ-030 The bench SHALL apply A=0x80000001, B=1 with opcode 110 and check out=2, C=1; then opcode 111 with the same operands and check out=0x40000000, C=1; then A=0x10000, B=0x10000 with opcode 010 and check out=0, C=1, Z=1.
REQ-031 The bench SHALL change operands every cycle for 8 back-to-back cycles and confirm each result appears exactly one cycle later; then assert rst mid-stream and confirm the reset values of REQ-023 appear immediately.
